// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared receiver state encoding, baud constant and width helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    // 7.3728 MHz / 115200 baud
    localparam int unsigned c_BAUD_DIV = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchroniser cell with active-low async reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RESET_VAL;
            r_q    <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Power-of-two FIFO with registered head word and occupancy count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [WIDTH-1:0]              i_data,
    input  logic                          i_pop,
    output logic [WIDTH-1:0]              o_data,
    output logic                          o_empty,
    output logic                          o_full,
    output logic [count_width(DEPTH)-1:0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = count_width(DEPTH);
    localparam logic [CW-1:0] c_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] c_ONE  = CW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;
    logic             w_do_push;
    logic             w_do_pop;
    logic [AW-1:0]    w_rd_inc;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_FULL);
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign w_rd_inc  = r_rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_inc;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Head tracks the entry that will be at the read pointer next cycle
            if (w_do_pop) begin
                if (r_count > c_ONE) begin
                    r_head <= r_mem[w_rd_inc];
                end else if (w_do_push) begin
                    r_head <= i_data;
                end
            end else if (w_do_push && o_empty) begin
                r_head <= i_data;
            end
        end
    end

    assign o_data  = r_head;
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Mid-bit sampling UART receiver feeding a FIFO, with RTS and errors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = c_BAUD_DIV,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned RTS_MARGIN   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    output logic                          rts,
    output logic [DATA_BITS-1:0]          data,
    output logic                          valid,
    input  logic                          ready,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          framing_err,
    output logic                          overflow_err,
    input  logic                          clear_err
);

    localparam int unsigned CCW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BCW = $clog2(DATA_BITS + 1);
    localparam int unsigned CW  = count_width(DEPTH);
    localparam logic [CCW-1:0] c_BIT_LAST  = CCW'(CLKS_PER_BIT - 1);
    localparam logic [CCW-1:0] c_HALF_LAST = CCW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BCW-1:0] c_DATA_LAST = BCW'(DATA_BITS - 1);
    localparam logic [CW-1:0]  c_RTS_LEVEL = CW'(DEPTH - RTS_MARGIN);

    rx_state_t            r_state,   w_state_nxt;
    logic [CCW-1:0]       r_clk_cnt, w_clk_cnt_nxt;
    logic [BCW-1:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic [DATA_BITS-1:0] r_shift,   w_shift_nxt;
    logic                 w_push;
    logic                 w_frame_err;
    logic                 w_rst_n;
    logic                 w_rx_s;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_empty;
    logic                 w_full;
    logic [CW-1:0]        w_count;
    logic                 r_rts;
    logic                 r_framing_err;
    logic                 r_overflow_err;

    assign w_rst_n = ~rst;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .i_rst_n (w_rst_n),
        .i_d     (rx),
        .o_q     (w_rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clk_cnt <= w_clk_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_push        = 1'b0;
        w_frame_err   = 1'b0;
        case (r_state)
            IDLE: begin
                w_clk_cnt_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt   = START;
                    w_bit_cnt_nxt = '0;
                end
            end
            START: begin
                if (r_clk_cnt == c_HALF_LAST) begin
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_clk_cnt == c_BIT_LAST) begin
                    w_clk_cnt_nxt = '0;
                    w_shift_nxt   = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == c_DATA_LAST) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (r_clk_cnt == c_BIT_LAST) begin
                    w_clk_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_push      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                // Held-low line must return high before a new start is seen
                w_clk_cnt_nxt = '0;
                if (w_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_clk_cnt_nxt = '0;
                w_state_nxt   = IDLE;
            end
        endcase
    end

    assign w_pop  = ready && !w_empty;
    assign w_drop = w_push && w_full && !w_pop;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (w_pop),
        .o_data  (data),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    // rts lags the occupancy by one cycle; a new error wins over a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rts          <= 1'b1;
            r_framing_err  <= 1'b0;
            r_overflow_err <= 1'b0;
        end else begin
            r_rts          <= (w_count >= c_RTS_LEVEL);
            r_framing_err  <= w_frame_err | (r_framing_err  & ~clear_err);
            r_overflow_err <= w_drop      | (r_overflow_err & ~clear_err);
        end
    end

    assign valid        = ~w_empty;
    assign count        = w_count;
    assign rts          = r_rts;
    assign framing_err  = r_framing_err;
    assign overflow_err = r_overflow_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Scoreboard bench for uart_rx_fifo with serial frame stimulus.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_fifo;

    localparam int CPB    = 64;
    localparam int DB     = 8;
    localparam int DEPTH  = 16;
    localparam int MARGIN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic       clear_err = 1'b0;
    logic       rts;
    logic       valid;
    logic       framing_err;
    logic       overflow_err;
    logic [7:0] data;
    logic [4:0] count;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB),
        .DEPTH        (DEPTH),
        .RTS_MARGIN   (MARGIN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .rts          (rts),
        .data         (data),
        .valid        (valid),
        .ready        (ready),
        .count        (count),
        .framing_err  (framing_err),
        .overflow_err (overflow_err),
        .clear_err    (clear_err)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] sb[$];
    int         mode = 0;
    bit         exp_ovf = 1'b0;
    bit         rnd_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: a frame with a good stop bit yields its word unless the
    // buffer already holds DEPTH unread words, in which case it is lost.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int idle);
        if (stop_ok) begin
            if (sb.size() >= DEPTH) exp_ovf = 1'b1;
            else                    sb.push_back(d);
        end
        rx = 1'b0;
        wait_clk(CPB);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            wait_clk(CPB);
        end
        rx = stop_ok;
        wait_clk(CPB);
        if (!stop_ok) wait_clk(1000);
        rx = 1'b1;
        wait_clk(idle);
    endtask

    task automatic drain();
        ready = 1'b1;
        wait_clk(DEPTH + 4);
        ready = 1'b0;
        check("drained_count", count, 0);
        check("drained_sb", sb.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks invariants
    initial begin
        int         prev_cnt;
        bit         prev_live;
        bit         prev_valid;
        logic [7:0] exp_d;
        prev_cnt   = 0;
        prev_live  = 1'b0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_live  = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (prev_live) check("rts_lag", rts, (prev_cnt >= DEPTH - MARGIN));
                check("valid_vs_count", valid, (count != 0));
                check("count_bound", (count <= DEPTH), 1);
                if (valid && ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_word: got 0x%0h, expected none", data);
                    end else begin
                        exp_d = sb.pop_front();
                        check("data_order", data, exp_d);
                    end
                end
                if (mode == 5) begin
                    check("b2b_count_le1", (count <= 1), 1);
                    check("b2b_one_cycle", (prev_valid && valid), 0);
                end
                prev_cnt   = count;
                prev_valid = valid;
                prev_live  = 1'b1;
            end
        end
    end

    initial begin
        int n;
        // Reset state
        wait_clk(3);
        check("rst_rts", rts, 1);
        check("rst_valid", valid, 0);
        check("rst_count", count, 0);
        check("rst_data", data, 0);
        check("rst_ferr", framing_err, 0);
        check("rst_oerr", overflow_err, 0);
        rst = 1'b0;
        wait_clk(5);

        // 1: single frame, latency from start edge to valid
        n = 0;
        fork
            send_frame(8'hA5, 1'b1, 20);
            begin
                while (!valid && n < 800) begin
                    @(negedge clk);
                    n++;
                end
            end
        join
        check("t1_latency_610pm1", ((n - 1) >= 609 && (n - 1) <= 611), 1);
        check("t1_data", data, 8'hA5);
        check("t1_count", count, 1);
        check("t1_ferr", framing_err, 0);
        check("t1_oerr", overflow_err, 0);
        drain();

        // 2: start-bit glitch is ignored
        rx = 1'b0;
        wait_clk(20);
        rx = 1'b1;
        wait_clk(200);
        check("t2_count", count, 0);
        check("t2_ferr", framing_err, 0);
        check("t2_oerr", overflow_err, 0);
        send_frame(8'h3C, 1'b1, 20);
        check("t2_count_after", count, 1);
        drain();

        // 3: framing error with long break, then recovery and clear
        send_frame(8'h3C, 1'b0, 20);
        check("t3_ferr", framing_err, 1);
        check("t3_not_stored", count, 0);
        send_frame(8'h11, 1'b1, 20);
        check("t3_count_after", count, 1);
        check("t3_ferr_sticky", framing_err, 1);
        drain();
        clear_err = 1'b1;
        wait_clk(1);
        clear_err = 1'b0;
        check("t3_ferr_cleared", framing_err, 0);

        // 4: fill past capacity, rts threshold, overflow, ordered drain
        for (int i = 0; i < 17; i++) begin
            send_frame(i[7:0], 1'b1, 20);
            check("t4_count", count, (i + 1 > DEPTH) ? DEPTH : i + 1);
            check("t4_rts", rts, ((i + 1) >= DEPTH - MARGIN));
            check("t4_oerr", overflow_err, exp_ovf);
        end
        check("t4_oerr_final", overflow_err, 1);
        drain();
        wait_clk(2);
        check("t4_rts_low", rts, 0);
        clear_err = 1'b1;
        wait_clk(1);
        clear_err = 1'b0;
        exp_ovf = 1'b0;
        check("t4_oerr_cleared", overflow_err, 0);

        // 5: back-to-back frames with ready held high
        ready = 1'b1;
        mode  = 5;
        send_frame(8'h55, 1'b1, 0);
        send_frame(8'hAA, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 20);
        mode  = 0;
        ready = 1'b0;
        check("t5_all_seen", sb.size(), 0);

        // 6: reset in the middle of the data bits
        rx = 1'b0;
        wait_clk(CPB * 3);
        rst = 1'b1;
        #1;
        check("t6_rst_rts", rts, 1);
        check("t6_rst_valid", valid, 0);
        check("t6_rst_count", count, 0);
        rx = 1'b1;
        wait_clk(3);
        check("t6_rst_count_hold", count, 0);
        rst = 1'b0;
        wait_clk(2000);
        check("t6_aborted_absent", count, 0);
        send_frame(8'h42, 1'b1, 20);
        check("t6_count_after", count, 1);
        drain();

        // Random words with random consumer back-pressure
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send_frame(8'($urandom_range(0, 255)), 1'b1, $urandom_range(0, 30));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    ready = 1'($urandom_range(0, 1));
                    wait_clk(1);
                end
            end
        join
        drain();
        check("rnd_ferr", framing_err, 0);
        check("rnd_oerr", overflow_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
